domain_tdm_scheduler: RTL

Time-division scheduler that shares the two-domain output mux between a low-side requester (domain 0, label L1) and a high-side requester (domain 1, label L2). It drives the mux select `sel` and the registered output word on a fixed, input-independent schedule. A scrub interval sits between every domain switch, so no data, timing or handshake behaviour of one domain is observable while the other owns the output. It sits between the two domain producers and the shared mux or consumer.

---
 rtl/domain_sched_pkg.sv | 22 ++
 rtl/slot_timer.sv | 39 +++
 rtl/domain_tdm_scheduler.sv | 102 ++++++++++
 3 files changed

// File: rtl/domain_sched_pkg.sv
// Shared types and constants for the two-domain TDM scheduler.
// Domain labels map directly onto the mux select value.
package domain_sched_pkg;

  typedef enum logic [1:0] {
    SLOT0  = 2'd0,
    SCRUB0 = 2'd1,
    SLOT1  = 2'd2,
    SCRUB1 = 2'd3
  } state_e;

  localparam logic DOM_L1 = 1'b0;
  localparam logic DOM_L2 = 1'b1;

  // Counter width for the longer of the two phases; never below one bit.
  function automatic int cnt_width(input int slice, input int scrub);
    int m;
    m = (slice > scrub) ? slice : scrub;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Phase counter for the scheduler: counts through a slot or a scrub and flags
// its last cycle. The count restarts whenever the phase ends.
module slot_timer
  import domain_sched_pkg::*;
#(
  parameter int SLICE = 8,
  parameter int SCRUB = 2,
  parameter int CW    = cnt_width(SLICE, SCRUB)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  state_e        state_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  localparam logic [CW-1:0] SLICE_LAST = CW'(SLICE - 1);
  localparam logic [CW-1:0] SCRUB_LAST = CW'(SCRUB - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_slot;

  always_comb begin
    is_slot = (state_i == SLOT0) || (state_i == SLOT1);
    tc_o    = (cnt_q == (is_slot ? SLICE_LAST : SCRUB_LAST));
    cnt_d   = tc_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/domain_tdm_scheduler.sv
// Fixed time-division owner of the shared two-domain output mux, with a
// scrub interval between owners so neither domain can observe the other.
module domain_tdm_scheduler
  import domain_sched_pkg::*;
#(
  parameter int DW    = 2,
  parameter int SLICE = 8,
  parameter int SCRUB = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vld0,
  input  logic [DW-1:0] din0,
  output logic          rdy0,
  input  logic          vld1,
  input  logic [DW-1:0] din1,
  output logic          rdy1,
  output logic          sel,
  output logic [DW-1:0] dout,
  output logic          dout_vld
);

  localparam int            CW         = cnt_width(SLICE, SCRUB);
  localparam logic [CW-1:0] SLICE_LAST = CW'(SLICE - 1);

  state_e        state_q, state_d;
  logic          sel_q, sel_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dout_vld_q, dout_vld_d;
  logic [CW-1:0] cnt;
  logic          tc;
  logic          xfer0, xfer1;

  slot_timer #(
    .SLICE (SLICE),
    .SCRUB (SCRUB),
    .CW    (CW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .state_i (state_q),
    .cnt_o   (cnt),
    .tc_o    (tc)
  );

  // The last slot cycle never accepts, so the final word is shown before the switch.
  assign rdy0  = (state_q == SLOT0) && (cnt < SLICE_LAST);
  assign rdy1  = (state_q == SLOT1) && (cnt < SLICE_LAST);
  assign xfer0 = vld0 && rdy0;
  assign xfer1 = vld1 && rdy1;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    if (xfer0) begin
      dout_d     = din0;
      dout_vld_d = 1'b1;
    end else if (xfer1) begin
      dout_d     = din1;
      dout_vld_d = 1'b1;
    end
    // Scrub entry hands sel to the incoming domain and wipes the output word.
    if (tc) begin
      case (state_q)
        SLOT0: begin
          state_d = SCRUB0;
          sel_d   = DOM_L2;
          dout_d  = '0;
        end
        SCRUB0: state_d = SLOT1;
        SLOT1: begin
          state_d = SCRUB1;
          sel_d   = DOM_L1;
          dout_d  = '0;
        end
        SCRUB1: state_d = SLOT0;
        default: state_d = SLOT0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SLOT0;
      sel_q      <= DOM_L1;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  assign sel      = sel_q;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;

endmodule
